alarm_clock_ctrl: RTL and testbench
===================================

Name: alarm_clock_ctrl

Overview:
- Sequencing FSM for the alarm clock datapath.
- Interprets keypad codes and decides what the four display-digit drivers show: current time, alarm time, or the key buffer.
- Issues one-cycle shift/load strobes to the key shift register and the alarm/time registers.
- Sits between the keypad decoder and the LCD driver; drives its show_a / show_current_time selects.

Parameters:
- TIMEOUT_S, 10, seconds of keypad inactivity before key entry is abandoned (range 2..15).
- NUM_DIGITS, 4, digits that must be entered before a set command is accepted.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- one_second  in  1  one-cycle strobe, once per second.
- key  in  4  keypad code: 0-9 digit, 10 NOKEY, 11 ALARM button, 12 TIME button, 13-15 treated as NOKEY.
- shift  out  1  one-cycle strobe: shift current digit into key buffer.
- load_new_a  out  1  one-cycle strobe: copy key buffer into alarm register.
- load_new_c  out  1  one-cycle strobe: copy key buffer into current-time counter.
- show_a  out  1  display alarm time.
- show_current_time  out  1  display key buffer; drives the LCD driver's show_current_time.
- entry_digits  out  3  digits entered in this entry session, saturating at NUM_DIGITS.

Behaviour:
- Moore FSM; all outputs decode from registered state and counters. No combinational path from key to outputs; one cycle of latency from key to strobe.
- States: SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTRY, SHOW_ALARM, SET_ALARM, SET_TIME.
- Reset (rst_n=0 at a clk edge): state=SHOW_TIME, timer=0, entry_digits=0; all outputs 0. This applies mid-entry too; a pending strobe is suppressed.
- SHOW_TIME:
  - digit -> KEY_STORED, entry_digits:=1, timer:=0.
  - ALARM -> SHOW_ALARM.
  - TIME/NOKEY -> stay.
- KEY_STORED: shift=1 for exactly this cycle; unconditionally -> KEY_WAITED.
- KEY_WAITED (held key; no repeat shift):
  - NOKEY -> KEY_ENTRY.
  - else timeout -> SHOW_TIME.
  - else stay.
- KEY_ENTRY:
  - digit -> KEY_STORED; entry_digits increments, saturating; timer:=0.
  - ALARM -> SET_ALARM if entry_digits==NUM_DIGITS, else SHOW_TIME (abort).
  - TIME -> SET_TIME under the same rule.
  - timeout -> SHOW_TIME.
  - Key action has priority over a timeout in the same cycle.
- SET_ALARM: load_new_a=1 for one cycle -> SHOW_ALARM. SET_TIME: load_new_c=1 for one cycle -> SHOW_TIME.
- SHOW_ALARM: show_a=1. NOKEY -> SHOW_TIME; any other code -> stay (display held while button is down).
- show_current_time=1 in KEY_STORED, KEY_WAITED, KEY_ENTRY; 0 elsewhere.
- show_a and show_current_time are never both 1.
- entry_digits clears on entering SHOW_TIME or SHOW_ALARM.
- Timer:
  - 4-bit; cleared on every transition into KEY_STORED; increments on one_second in KEY_WAITED/KEY_ENTRY.
  - timeout = one_second && timer==TIMEOUT_S-1; the timer never wraps.
  - A one_second strobe in the cycle of entry into KEY_STORED is not counted.
- At most one of shift/load_new_a/load_new_c is high per cycle.

Decomposition:
- Shared package alarm_clock_pkg: key code constants (KEY_NONE=10, KEY_ALARM=11, KEY_TIME=12), state enum typedef, and the digit-code predicate is_digit (key<=9).
- One sub-module is natural: inactivity_timer (clear, tick, timeout output), parameterised by TIMEOUT_S.

Test Plan:
- Reset: hold rst_n=0 3 cycles during KEY_ENTRY -> state SHOW_TIME; all outputs 0; entry_digits=0.
- Set current time: keys 1,2,3,4, each followed by NOKEY, then TIME -> exactly 4 shift pulses, show_current_time=1 during entry, then one load_new_c pulse, then SHOW_TIME.
- Set alarm: keys 0,7,3,0 then ALARM -> one load_new_a pulse. Holding ALARM keeps show_a=1; NOKEY returns show_a to 0.
- Short entry: keys 5,9 then TIME -> no load_new_c; SHOW_TIME; entry_digits=0.
- Timeout: one digit, then NOKEY with 10 one_second strobes -> SHOW_TIME after the 10th strobe. A digit arriving with the 10th strobe instead yields KEY_STORED and restarts the timer.
- Key held: digit 6 held 50 cycles -> exactly one shift; state remains KEY_WAITED until NOKEY.

Source files
------------

// File: rtl/alarm_clock_ctrl_pkg.sv
// Shared definitions for the alarm clock controller: key codes, state encoding
// and keypad code predicates.
package alarm_clock_pkg;

  localparam logic [3:0] KEY_NONE  = 4'd10;
  localparam logic [3:0] KEY_ALARM = 4'd11;
  localparam logic [3:0] KEY_TIME  = 4'd12;

  typedef logic [2:0] state_t;

  localparam state_t SHOW_TIME  = 3'd0;
  localparam state_t KEY_STORED = 3'd1;
  localparam state_t KEY_WAITED = 3'd2;
  localparam state_t KEY_ENTRY  = 3'd3;
  localparam state_t SHOW_ALARM = 3'd4;
  localparam state_t SET_ALARM  = 3'd5;
  localparam state_t SET_TIME   = 3'd6;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

  // Codes 13-15 are unused by the keypad decoder and behave like "no key".
  function automatic logic is_no_key(input logic [3:0] key);
    return (key == KEY_NONE) || (key >= 4'd13);
  endfunction

endpackage

// File: rtl/alarm_clock_ctrl_if.sv
// Keypad-side inputs and display/register-side strobes of the controller.
interface alarm_clock_ctrl_if;

  logic       one_second;
  logic [3:0] key;
  logic       shift;
  logic       load_new_a;
  logic       load_new_c;
  logic       show_a;
  logic       show_current_time;
  logic [2:0] entry_digits;

  modport master (
    output one_second, key,
    input  shift, load_new_a, load_new_c, show_a, show_current_time, entry_digits
  );

  modport slave (
    input  one_second, key,
    output shift, load_new_a, load_new_c, show_a, show_current_time, entry_digits
  );

endinterface

// File: rtl/alarm_clock_ctrl_inactivity_timer.sv
// Counts one-second ticks of keypad inactivity and flags the tick that
// reaches TIMEOUT_S. The count saturates instead of wrapping.
module inactivity_timer #(
  parameter int TIMEOUT_S = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic timeout
);

  localparam logic [3:0] LAST_COUNT = 4'(TIMEOUT_S - 1);

  logic [3:0] count;

  // Clear wins over a simultaneous tick so a restarted entry starts from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (clear) begin
      count <= 4'd0;
    end else if (tick && (count != 4'hF)) begin
      count <= count + 4'd1;
    end
  end

  assign timeout = tick && (count == LAST_COUNT);

endmodule

// File: rtl/alarm_clock_ctrl.sv
// Sequencing FSM of the alarm clock: interprets keypad codes, issues shift and
// load strobes, and selects what the LCD driver displays.
module alarm_clock_ctrl
  import alarm_clock_pkg::*;
#(
  parameter int TIMEOUT_S  = 10,
  parameter int NUM_DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alarm_clock_ctrl_if.slave   bus
);

  localparam logic [2:0] FULL_ENTRY = 3'(NUM_DIGITS);

  state_t     state;
  state_t     state_next;
  logic [2:0] digits;
  logic [2:0] digits_next;
  logic       timer_clear;
  logic       timer_tick;
  logic       timeout;

  // Only the waiting states age the entry; a strobe while in KEY_STORED is ignored.
  assign timer_tick = bus.one_second && ((state == KEY_WAITED) || (state == KEY_ENTRY));

  inactivity_timer #(
    .TIMEOUT_S (TIMEOUT_S)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .tick    (timer_tick),
    .timeout (timeout)
  );

  // Next-state and digit-count decisions; key actions take priority over a timeout.
  always_comb begin
    state_next  = state;
    digits_next = digits;
    timer_clear = 1'b0;
    case (state)
      SHOW_TIME: begin
        if (is_digit(bus.key)) begin
          state_next  = KEY_STORED;
          digits_next = 3'd1;
          timer_clear = 1'b1;
        end else if (bus.key == KEY_ALARM) begin
          state_next = SHOW_ALARM;
        end
      end
      KEY_STORED: begin
        state_next = KEY_WAITED;
      end
      KEY_WAITED: begin
        if (is_no_key(bus.key)) begin
          state_next = KEY_ENTRY;
        end else if (timeout) begin
          state_next = SHOW_TIME;
        end
      end
      KEY_ENTRY: begin
        if (is_digit(bus.key)) begin
          state_next  = KEY_STORED;
          timer_clear = 1'b1;
          if (digits < FULL_ENTRY) begin
            digits_next = digits + 3'd1;
          end
        end else if (bus.key == KEY_ALARM) begin
          state_next = (digits == FULL_ENTRY) ? SET_ALARM : SHOW_TIME;
        end else if (bus.key == KEY_TIME) begin
          state_next = (digits == FULL_ENTRY) ? SET_TIME : SHOW_TIME;
        end else if (timeout) begin
          state_next = SHOW_TIME;
        end
      end
      SHOW_ALARM: begin
        if (is_no_key(bus.key)) begin
          state_next = SHOW_TIME;
        end
      end
      SET_ALARM: begin
        state_next = SHOW_ALARM;
      end
      SET_TIME: begin
        state_next = SHOW_TIME;
      end
      default: begin
        state_next = SHOW_TIME;
      end
    endcase
    if ((state_next == SHOW_TIME) || (state_next == SHOW_ALARM)) begin
      digits_next = 3'd0;
    end
  end

  // State and entry-digit registers; reset also drops any strobe about to be issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= SHOW_TIME;
      digits <= 3'd0;
    end else begin
      state  <= state_next;
      digits <= digits_next;
    end
  end

  assign bus.shift             = (state == KEY_STORED);
  assign bus.load_new_a        = (state == SET_ALARM);
  assign bus.load_new_c        = (state == SET_TIME);
  assign bus.show_a            = (state == SHOW_ALARM);
  assign bus.show_current_time = (state == KEY_STORED) || (state == KEY_WAITED) ||
                                 (state == KEY_ENTRY);
  assign bus.entry_digits      = digits;

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Directed bench for alarm_clock_ctrl: each stimulus cycle pushes its
// hand-computed expected outputs; a monitor pops and compares after each edge.
module tb_alarm_clock_ctrl;

  localparam logic [3:0] NK = 4'd10;
  localparam logic [3:0] KA = 4'd11;
  localparam logic [3:0] KT = 4'd12;

  // Output pattern order: {shift, load_new_a, load_new_c, show_a, show_current_time}
  localparam logic [4:0] O_IDLE  = 5'b00000;
  localparam logic [4:0] O_SHIFT = 5'b10001;
  localparam logic [4:0] O_ENTRY = 5'b00001;
  localparam logic [4:0] O_ALARM = 5'b00010;
  localparam logic [4:0] O_LA    = 5'b01000;
  localparam logic [4:0] O_LC    = 5'b00100;

  typedef struct {
    logic [7:0] val;
    string      name;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb_q[$];
  int   vectors;
  int   miscompares;

  alarm_clock_ctrl_if bus();

  alarm_clock_ctrl #(
    .TIMEOUT_S  (10),
    .NUM_DIGITS (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic [3:0] k, input logic os,
                               input logic [4:0] o, input logic [2:0] d, input string name);
    exp_t e;
    @(negedge clk);
    rst_n          = r;
    bus.key        = k;
    bus.one_second = os;
    e.val  = {o, d};
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic enterDigit(input logic [3:0] dig, input logic [2:0] ed, input string name);
    applyStimulus(1'b1, dig, 1'b0, O_SHIFT, ed, name);
    applyStimulus(1'b1, NK,  1'b0, O_ENTRY, ed, name);
    applyStimulus(1'b1, NK,  1'b0, O_ENTRY, ed, name);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [7:0] got;
    got = {bus.shift, bus.load_new_a, bus.load_new_c, bus.show_a,
           bus.show_current_time, bus.entry_digits};
    vectors++;
    if (got !== e.val) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b_%b required %b_%b", e.name,
               got[7:3], got[2:0], e.val[7:3], e.val[2:0]);
    end
  endtask

  // Monitor: compare one expected entry per clock edge, sampled after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        checkOutput(sb_q.pop_front());
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n          = 1'b0;
    bus.key        = NK;
    bus.one_second = 1'b0;

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, NK, 1'b0, O_IDLE, 3'd0, "reset_init");
    applyStimulus(1'b1, NK, 1'b0, O_IDLE, 3'd0, "idle");
    applyStimulus(1'b1, KT, 1'b0, O_IDLE, 3'd0, "time_btn_idle");

    // Reset during KEY_ENTRY while a digit is pressed: no shift afterwards
    enterDigit(4'd1, 3'd1, "rst_entry_d1");
    enterDigit(4'd2, 3'd2, "rst_entry_d2");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd3, 1'b0, O_IDLE, 3'd0, "reset_mid_entry");
    applyStimulus(1'b1, NK, 1'b0, O_IDLE, 3'd0, "after_reset");

    // Set current time 1234
    enterDigit(4'd1, 3'd1, "time_d1");
    enterDigit(4'd2, 3'd2, "time_d2");
    enterDigit(4'd3, 3'd3, "time_d3");
    enterDigit(4'd4, 3'd4, "time_d4");
    applyStimulus(1'b1, KT, 1'b0, O_LC,   3'd4, "load_c");
    applyStimulus(1'b1, NK, 1'b0, O_IDLE, 3'd0, "after_load_c");

    // Set alarm 0730; one release uses code 15 as no-key
    enterDigit(4'd0, 3'd1, "alarm_d0");
    applyStimulus(1'b1, 4'd7, 1'b0, O_SHIFT, 3'd2, "alarm_d7");
    applyStimulus(1'b1, 4'd7, 1'b0, O_ENTRY, 3'd2, "alarm_d7_held");
    applyStimulus(1'b1, 4'd15, 1'b0, O_ENTRY, 3'd2, "code15_release");
    enterDigit(4'd3, 3'd3, "alarm_d3");
    enterDigit(4'd0, 3'd4, "alarm_d0b");
    applyStimulus(1'b1, KA, 1'b0, O_LA,    3'd4, "load_a");
    applyStimulus(1'b1, KA, 1'b0, O_ALARM, 3'd0, "show_alarm");
    applyStimulus(1'b1, KA, 1'b0, O_ALARM, 3'd0, "alarm_held");
    applyStimulus(1'b1, NK, 1'b0, O_IDLE,  3'd0, "alarm_release");

    // ALARM button from idle shows the alarm directly
    applyStimulus(1'b1, KA, 1'b0, O_ALARM, 3'd0, "alarm_from_idle");
    applyStimulus(1'b1, NK, 1'b0, O_IDLE,  3'd0, "alarm_from_idle_rel");

    // Five digits saturate the count at four, then ALARM loads
    enterDigit(4'd1, 3'd1, "sat_d1");
    enterDigit(4'd2, 3'd2, "sat_d2");
    enterDigit(4'd3, 3'd3, "sat_d3");
    enterDigit(4'd4, 3'd4, "sat_d4");
    enterDigit(4'd5, 3'd4, "sat_d5");
    applyStimulus(1'b1, KA, 1'b0, O_LA,    3'd4, "sat_load_a");
    applyStimulus(1'b1, NK, 1'b0, O_ALARM, 3'd0, "sat_show_alarm");
    applyStimulus(1'b1, NK, 1'b0, O_IDLE,  3'd0, "sat_back");

    // Short entries abort without loading
    enterDigit(4'd5, 3'd1, "short_d5");
    enterDigit(4'd9, 3'd2, "short_d9");
    applyStimulus(1'b1, KT, 1'b0, O_IDLE, 3'd0, "short_time_abort");
    applyStimulus(1'b1, NK, 1'b0, O_IDLE, 3'd0, "short_idle");
    enterDigit(4'd8, 3'd1, "short_a_d8");
    applyStimulus(1'b1, KA, 1'b0, O_IDLE, 3'd0, "short_alarm_abort");
    applyStimulus(1'b1, NK, 1'b0, O_IDLE, 3'd0, "short_alarm_idle");

    // Timeout after ten strobes in KEY_ENTRY
    enterDigit(4'd8, 3'd1, "to_d8");
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, NK, 1'b1, O_ENTRY, 3'd1, "to_counting");
    applyStimulus(1'b1, NK, 1'b0, O_ENTRY, 3'd1, "to_no_strobe");
    applyStimulus(1'b1, NK, 1'b1, O_IDLE,  3'd0, "to_expire");

    // Strobe during KEY_STORED is ignored; digit with 10th strobe restarts timer
    applyStimulus(1'b1, 4'd4, 1'b0, O_SHIFT, 3'd1, "rs_d4");
    applyStimulus(1'b1, NK,   1'b1, O_ENTRY, 3'd1, "rs_stored_strobe");
    applyStimulus(1'b1, NK,   1'b0, O_ENTRY, 3'd1, "rs_entry");
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, NK, 1'b1, O_ENTRY, 3'd1, "rs_counting");
    applyStimulus(1'b1, 4'd6, 1'b1, O_SHIFT, 3'd2, "rs_key_beats_timeout");
    applyStimulus(1'b1, NK,   1'b0, O_ENTRY, 3'd2, "rs_wait2");
    applyStimulus(1'b1, NK,   1'b0, O_ENTRY, 3'd2, "rs_entry2");
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, NK, 1'b1, O_ENTRY, 3'd2, "rs_recount");
    applyStimulus(1'b1, NK, 1'b1, O_IDLE, 3'd0, "rs_expire");

    // Held key times out in KEY_WAITED
    applyStimulus(1'b1, 4'd9, 1'b0, O_SHIFT, 3'd1, "hw_d9");
    applyStimulus(1'b1, 4'd9, 1'b1, O_ENTRY, 3'd1, "hw_stored_strobe");
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 4'd9, 1'b1, O_ENTRY, 3'd1, "hw_counting");
    applyStimulus(1'b1, 4'd9, 1'b1, O_IDLE, 3'd0, "hw_expire");
    applyStimulus(1'b1, NK,   1'b0, O_IDLE, 3'd0, "hw_idle");

    // Digit 6 held 50 cycles: a single shift, then waiting until release
    applyStimulus(1'b1, 4'd6, 1'b0, O_SHIFT, 3'd1, "held_shift");
    for (int i = 0; i < 49; i++) applyStimulus(1'b1, 4'd6, 1'b0, O_ENTRY, 3'd1, "held_wait");
    applyStimulus(1'b1, NK, 1'b0, O_ENTRY, 3'd1, "held_release");
    applyStimulus(1'b1, KT, 1'b0, O_IDLE,  3'd0, "held_abort");
    applyStimulus(1'b1, NK, 1'b0, O_IDLE,  3'd0, "final_idle");

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    #3;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending entries required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
